// File: rtl/fifo_arb_ctrl.sv
// rtl/fifo_arb_ctrl.sv - round-robin write arbiter, pointers and registered read in front of fifo_mem
// Optional almost_full output is built only when FIFO_ARB_ALMOST_FULL_EN is defined.
module fifo_arb_ctrl #(
  parameter int ADDR_SIZE = 4,
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4,
  parameter int AF_THRESH = 12
) (
  input  logic                           w_clk,
  input  logic                           w_rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic                           rd_en,
  output logic [DATA_SIZE-1:0]           rd_data,
  output logic                           rd_valid,
  output logic                           full,
  output logic                           empty,
  output logic [ADDR_SIZE:0]             count,
`ifdef FIFO_ARB_ALMOST_FULL_EN
  output logic                           almost_full,
`endif
  output logic                           mem_w_en,
  output logic                           mem_w_full,
  output logic [ADDR_SIZE-1:0]           mem_w_addr,
  output logic [DATA_SIZE-1:0]           mem_w_data,
  output logic [ADDR_SIZE-1:0]           mem_r_addr,
  input  logic [DATA_SIZE-1:0]           mem_r_data
);

  localparam int              RR_W    = $clog2(NUM_REQ);
  localparam logic [RR_W-1:0] RR_INIT = RR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || AF_THRESH < 1) begin : g_bad_params
    $error("fifo_arb_ctrl: NUM_REQ must be >= 2 and AF_THRESH >= 1");
  end

  logic [ADDR_SIZE:0]   wptr_q, wptr_d;
  logic [ADDR_SIZE:0]   rptr_q, rptr_d;
  logic [RR_W-1:0]      rr_last_q, rr_last_d;
  logic [DATA_SIZE-1:0] rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;

  logic [NUM_REQ-1:0]   grant;
  logic [RR_W-1:0]      grant_idx;
  logic                 grant_found;
  logic                 wr_acc;
  logic                 rd_acc;

  // Occupancy flags come straight from the registered pointers.
  assign count = wptr_q - rptr_q;
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[ADDR_SIZE] != rptr_q[ADDR_SIZE]) &&
                 (wptr_q[ADDR_SIZE-1:0] == rptr_q[ADDR_SIZE-1:0]);

`ifdef FIFO_ARB_ALMOST_FULL_EN
  localparam logic [ADDR_SIZE:0] AF_LEVEL = (ADDR_SIZE+1)'(AF_THRESH);
  assign almost_full = (count >= AF_LEVEL);
`endif

  // Scan starts one past the last winner; grants are suppressed while in reset.
  always_comb begin
    grant       = '0;
    grant_idx   = rr_last_q;
    grant_found = 1'b0;
    if (!w_rst && !full) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (!grant_found && req[(int'(rr_last_q) + k) % NUM_REQ]) begin
          grant_found                               = 1'b1;
          grant[(int'(rr_last_q) + k) % NUM_REQ]    = 1'b1;
          grant_idx                                 = RR_W'((int'(rr_last_q) + k) % NUM_REQ);
        end
      end
    end
  end

  always_comb begin
    mem_w_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        mem_w_data = mem_w_data | req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign wr_acc = |grant;
  assign rd_acc = rd_en && !empty;

  assign gnt        = grant;
  assign mem_w_en   = wr_acc;
  assign mem_w_full = full;
  assign mem_w_addr = wptr_q[ADDR_SIZE-1:0];
  assign mem_r_addr = rptr_q[ADDR_SIZE-1:0];
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

  always_comb begin
    wptr_d     = wptr_q + {{ADDR_SIZE{1'b0}}, wr_acc};
    rptr_d     = rptr_q + {{ADDR_SIZE{1'b0}}, rd_acc};
    rr_last_d  = wr_acc ? grant_idx : rr_last_q;
    rd_data_d  = rd_acc ? mem_r_data : rd_data_q;
    rd_valid_d = rd_acc;
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      rr_last_q  <= RR_INIT;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      rr_last_q  <= rr_last_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// tb/tb_fifo_arb_ctrl.sv - directed bench for fifo_arb_ctrl with a behavioural fifo_mem
module tb_fifo_arb_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int NR    = 4;
  localparam int DEPTH = 1 << AW;

  logic              w_clk = 1'b0;
  logic              w_rst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              rd_en;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
`ifdef FIFO_ARB_ALMOST_FULL_EN
  logic              almost_full;
`endif
  logic              mem_w_en;
  logic              mem_w_full;
  logic [AW-1:0]     mem_w_addr;
  logic [DW-1:0]     mem_w_data;
  logic [AW-1:0]     mem_r_addr;
  logic [DW-1:0]     mem_r_data;

  logic [DW-1:0]     mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 w_clk = ~w_clk;

  always @(posedge w_clk) begin
    if (mem_w_en && !mem_w_full) mem[mem_w_addr] <= mem_w_data;
  end
  assign mem_r_data = mem[mem_r_addr];

  fifo_arb_ctrl #(
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW),
    .NUM_REQ   (NR),
    .AF_THRESH (12)
  ) dut (
    .w_clk       (w_clk),
    .w_rst       (w_rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .count       (count),
`ifdef FIFO_ARB_ALMOST_FULL_EN
    .almost_full (almost_full),
`endif
    .mem_w_en    (mem_w_en),
    .mem_w_full  (mem_w_full),
    .mem_w_addr  (mem_w_addr),
    .mem_w_data  (mem_w_data),
    .mem_r_addr  (mem_r_addr),
    .mem_r_data  (mem_r_data)
  );

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge w_clk);
    #1;
  endtask

  logic [DW-1:0] sb[$];
  logic [NR-1:0] exp_gnt;
  logic [DW-1:0] exp_rd;
  logic          rd_ok;
  logic          wr;
  int            r;

  initial begin
    w_rst    = 1'b1;
    req      = 4'b1111;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    rd_en    = 1'b0;

    // Reset held two cycles with all requests up
    tick;
    expect_eq("rst_gnt_mid", gnt, 4'b0000);
    tick;
    expect_eq("rst_gnt", gnt, 4'b0000);
    expect_eq("rst_mem_w_en", mem_w_en, 1'b0);
    expect_eq("rst_empty", empty, 1'b1);
    expect_eq("rst_full", full, 1'b0);
    expect_eq("rst_count", count, 5'd0);
    expect_eq("rst_rd_valid", rd_valid, 1'b0);
    expect_eq("rst_rd_data", rd_data, 8'h00);
`ifdef FIFO_ARB_ALMOST_FULL_EN
    expect_eq("rst_almost_full", almost_full, 1'b0);
`endif
    w_rst = 1'b0;

    // Round-robin with all four requesting
    for (int i = 0; i < 8; i++) begin
      #1;
      expect_eq("rr_gnt", gnt, 32'(1 << (i % 4)));
      expect_eq("rr_w_data", mem_w_data, 32'(8'hA0 + (i % 4)));
      tick;
    end
    req = 4'b0000;
    expect_eq("rr_count", count, 5'd8);

    rd_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      expect_eq("rr_rd_valid", rd_valid, 1'b1);
      expect_eq("rr_rd_data", rd_data, 32'(8'hA0 + (i % 4)));
    end
    rd_en = 1'b0;
    expect_eq("rr_drained_empty", empty, 1'b1);

    // Fill from requester 2
    req = 4'b0100;
    for (int i = 0; i < DEPTH; i++) begin
      req_data[2*DW +: DW] = 8'(i);
      #1;
      expect_eq("fill_gnt", gnt, 4'b0100);
      tick;
    end
    req_data[2*DW +: DW] = 8'h10;
    expect_eq("fill_full", full, 1'b1);
    expect_eq("fill_empty", empty, 1'b0);
    expect_eq("fill_count", count, 5'd16);
    #1;
    expect_eq("fill_gnt_when_full", gnt, 4'b0000);

    // Full with simultaneous read: read wins, no grant
    req   = 4'b0001;
    rd_en = 1'b1;
    #1;
    expect_eq("fullrd_gnt", gnt, 4'b0000);
    expect_eq("fullrd_mem_w_en", mem_w_en, 1'b0);
    tick;
    req = 4'b0000;
    expect_eq("fullrd_rd_valid", rd_valid, 1'b1);
    expect_eq("fullrd_rd_data", rd_data, 8'h00);
    expect_eq("fullrd_count", count, 5'd15);
    expect_eq("fullrd_full", full, 1'b0);

    // Drain the rest, then read while empty
    for (int i = 1; i < DEPTH; i++) begin
      tick;
      expect_eq("drain_rd_valid", rd_valid, 1'b1);
      expect_eq("drain_rd_data", rd_data, 32'(i));
    end
    expect_eq("drain_empty", empty, 1'b1);
    expect_eq("drain_count", count, 5'd0);
    tick;
    expect_eq("empty_rd_valid", rd_valid, 1'b0);
    expect_eq("empty_rd_data_hold", rd_data, 8'h0F);
    rd_en = 1'b0;

    // Mixed traffic across pointer wrap against a scoreboard
    for (int c = 0; c < 40; c++) begin
      wr    = (c < 20) ? 1'b1 : (c % 3 == 0);
      rd_en = (c < 20) ? ((c % 3 == 2) || (c == 0)) : 1'b1;
      r     = c % NR;
      req   = wr ? NR'(1 << r) : '0;
      for (int l = 0; l < NR; l++) req_data[l*DW +: DW] = 8'((c << 2) | l);
      #1;
      exp_gnt = (wr && sb.size() < DEPTH) ? NR'(1 << r) : '0;
      expect_eq("mix_gnt", gnt, exp_gnt);
      expect_eq("mix_count", count, sb.size());
      expect_eq("mix_empty", empty, sb.size() == 0);
      expect_eq("mix_full", full, sb.size() == DEPTH);
`ifdef FIFO_ARB_ALMOST_FULL_EN
      expect_eq("mix_almost_full", almost_full, sb.size() >= 12);
`endif
      rd_ok  = rd_en && (sb.size() > 0);
      exp_rd = '0;
      if (rd_ok) exp_rd = sb.pop_front();
      if (exp_gnt != '0) sb.push_back(8'((c << 2) | r));
      tick;
      expect_eq("mix_rd_valid", rd_valid, rd_ok);
      if (rd_ok) expect_eq("mix_rd_data", rd_data, exp_rd);
    end
    req   = '0;
    rd_en = 1'b0;
    expect_eq("mix_final_count", count, sb.size());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
